// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// The FSM encoding and the divide-by-zero quotient live here so that the top and its users agree.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_W     = 16;
    localparam int DW        = 2 * DEF_W;
    localparam int ITER_LAST = DW - 1;

    localparam logic [DW-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor in W+1 bits and restore on a negative result.
module div_step
    import div_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W:0]   r,
    input  logic         din,
    input  logic [W-1:0] divisor,
    output logic [W:0]   r_new,
    output logic         qbit
);

    logic [W:0] t;
    logic       unused_r_msb;

    // R < divisor holds between steps, so its MSB never carries into T.
    assign unused_r_msb = r[W];
    assign t            = {r[W-1:0], din};

    always_comb begin
        r_new = t;
        qbit  = 1'b0;
        if (t >= {1'b0, divisor}) begin
            r_new = t - {1'b0, divisor};
            qbit  = 1'b1;
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock,
// valid/ready handshakes on both sides.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);

    state_t         state;
    state_t         next_state;
    logic [2*W-1:0] q_reg;
    logic [W:0]     r_reg;
    logic [W-1:0]   d_reg;
    logic [CW-1:0]  cnt;
    logic           dz_reg;
    logic [W:0]     r_next;
    logic           q_bit;

    div_step #(.W(W)) u_step (
        .r       (r_reg),
        .din     (q_reg[2*W-1]),
        .divisor (d_reg),
        .r_new   (r_next),
        .qbit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid) next_state = (divisor == '0) ? DONE : BUSY;
            BUSY: if (cnt == '0) next_state = DONE;
            DONE: if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Results are only driven while DONE so a partially shifted quotient never leaks out.
    always_comb begin
        in_ready    = (state == IDLE);
        out_valid   = (state == DONE);
        quotient    = '0;
        remainder   = '0;
        div_by_zero = 1'b0;
        if (state == DONE) begin
            quotient    = q_reg;
            remainder   = r_reg[W-1:0];
            div_by_zero = dz_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg  <= '0;
            r_reg  <= '0;
            d_reg  <= '0;
            cnt    <= '0;
            dz_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_reg  <= divisor;
                        dz_reg <= (divisor == '0);
                        if (divisor == '0) begin
                            q_reg <= {(2*W){1'b1}};
                            r_reg <= {1'b0, dividend[W-1:0]};
                        end else begin
                            q_reg <= dividend;
                            r_reg <= '0;
                            cnt   <= CW'(2*W-1);
                        end
                    end
                end
                BUSY: begin
                    q_reg <= {q_reg[2*W-2:0], q_bit};
                    r_reg <= r_next;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
